// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: rotates the IF/ID/ALU/MEM/RB phase
// strobes, owns the program counter and retires instructions at the end of
// the RB phase (halt, jump, register jump, conditional branch or fall-through).
module phase_sequencer #(
    parameter int              PC_W      = 16,
    parameter int              PHASE_LEN = 4,
    parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    input  logic [3:0]      branch_opcode,
    input  logic            alu_zero,
    input  logic            alu_lsb,
    input  logic [PC_W-1:0] jmp_target,
    input  logic [PC_W-1:0] jr_target,
    input  logic [PC_W-1:0] br_offset,
    output logic            IF_clk,
    output logic            ID_clk,
    output logic            ALU_clk,
    output logic            MEM_clk,
    output logic            RB_BR_clk,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            halted,
    output logic [31:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF     = 3'd1,
        S_ID     = 3'd2,
        S_ALU    = 3'd3,
        S_MEM    = 3'd4,
        S_RB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    // Phase counter is 4 bits wide, enough for the largest legal PHASE_LEN (16).
    localparam logic [3:0]      LAST_CNT = 4'(PHASE_LEN - 1);
    localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_r, state_s;
    logic [3:0]      phase_cnt_r, phase_cnt_s;
    logic [PC_W-1:0] pc_s;
    logic [31:0]     instr_count_s;
    logic [PC_W-1:0] branch_pc_s;
    logic            phase_last_s;

    // Next-PC selection for a non-halting retire; only consumed at the decision point.
    always_comb begin
        branch_pc_s = pc + PC_ONE;
        if (branch_opcode[2]) begin
            case (branch_opcode[1:0])
                2'b00:   branch_pc_s = jmp_target;
                2'b01:   branch_pc_s = jr_target;
                2'b10:   branch_pc_s = alu_zero ? (pc + br_offset) : (pc + PC_ONE);
                2'b11:   branch_pc_s = alu_lsb  ? (pc + br_offset) : (pc + PC_ONE);
                default: branch_pc_s = pc + PC_ONE;
            endcase
        end else begin
            branch_pc_s = pc + PC_ONE;
        end
    end

    // Next-state, phase counter, PC and retire-count logic.
    always_comb begin
        state_s       = state_r;
        phase_cnt_s   = phase_cnt_r;
        pc_s          = pc;
        instr_count_s = instr_count;
        phase_last_s  = (phase_cnt_r == LAST_CNT);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s     = S_IF;
                    phase_cnt_s = 4'd0;
                end else begin
                    phase_cnt_s = 4'd0;
                end
            end
            S_IF, S_ID, S_ALU, S_MEM: begin
                if (phase_last_s) begin
                    phase_cnt_s = 4'd0;
                    state_s     = state_t'(state_r + 3'd1);
                end else begin
                    phase_cnt_s = phase_cnt_r + 4'd1;
                end
            end
            S_RB: begin
                if (phase_last_s) begin
                    phase_cnt_s   = 4'd0;
                    instr_count_s = instr_count + 32'd1;
                    if (halt) begin
                        state_s = S_HALTED;
                    end else begin
                        state_s = S_IF;
                        pc_s    = branch_pc_s;
                    end
                end else begin
                    phase_cnt_s = phase_cnt_r + 4'd1;
                end
            end
            S_HALTED: begin
                phase_cnt_s = 4'd0;
            end
            default: begin
                // Unreachable encoding: fall back to a safe idle state.
                state_s     = S_IDLE;
                phase_cnt_s = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs; strobes are decoded from the
    // next state so they line up with cycle 0 of each phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            phase_cnt_r <= 4'd0;
            pc          <= RESET_PC;
            instr_count <= 32'd0;
            IF_clk      <= 1'b0;
            ID_clk      <= 1'b0;
            ALU_clk     <= 1'b0;
            MEM_clk     <= 1'b0;
            RB_BR_clk   <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            pc          <= pc_s;
            instr_count <= instr_count_s;
            IF_clk      <= (state_s == S_IF)  && (phase_cnt_s == 4'd0);
            ID_clk      <= (state_s == S_ID)  && (phase_cnt_s == 4'd0);
            ALU_clk     <= (state_s == S_ALU) && (phase_cnt_s == 4'd0);
            MEM_clk     <= (state_s == S_MEM) && (phase_cnt_s == 4'd0);
            RB_BR_clk   <= (state_s == S_RB)  && (phase_cnt_s == 4'd0);
            running     <= (state_s == S_IF) || (state_s == S_ID) || (state_s == S_ALU) ||
                           (state_s == S_MEM) || (state_s == S_RB);
            halted      <= (state_s == S_HALTED);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench for phase_sequencer against an
// instruction-level reference model (cycle offset within the instruction).
module tb_phase_sequencer;

    localparam int PC_W = 16;
    localparam int PL   = 4;
    localparam int ILEN = 5 * PL;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            halt;
    logic [3:0]      branch_opcode;
    logic            alu_zero;
    logic            alu_lsb;
    logic [PC_W-1:0] jmp_target;
    logic [PC_W-1:0] jr_target;
    logic [PC_W-1:0] br_offset;
    logic            IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk;
    logic [PC_W-1:0] pc;
    logic            running;
    logic            halted;
    logic [31:0]     instr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 running, 2 halted; m_k = cycle within instruction.
    int              m_mode;
    int              m_k;
    logic [PC_W-1:0] m_pc;
    logic [31:0]     m_cnt;

    phase_sequencer #(.PC_W(PC_W), .PHASE_LEN(PL), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .branch_opcode(branch_opcode), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
        .jmp_target(jmp_target), .jr_target(jr_target), .br_offset(br_offset),
        .IF_clk(IF_clk), .ID_clk(ID_clk), .ALU_clk(ALU_clk), .MEM_clk(MEM_clk),
        .RB_BR_clk(RB_BR_clk), .pc(pc), .running(running), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_k    = 0;
        m_pc   = 16'h0000;
        m_cnt  = 32'd0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_k    = 0;
            end
        end else if (m_mode == 1) begin
            if (m_k == ILEN - 1) begin
                m_cnt = m_cnt + 32'd1;
                m_k   = 0;
                if (halt) begin
                    m_mode = 2;
                end else if (branch_opcode[2]) begin
                    case (branch_opcode[1:0])
                        2'b00: m_pc = jmp_target;
                        2'b01: m_pc = jr_target;
                        2'b10: m_pc = alu_zero ? m_pc + br_offset : m_pc + 16'd1;
                        default: m_pc = alu_lsb ? m_pc + br_offset : m_pc + 16'd1;
                    endcase
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end else begin
                m_k = m_k + 1;
            end
        end
    endtask

    task automatic model_check();
        logic [4:0] exp_strb;
        logic [4:0] got_strb;
        exp_strb = 5'b00000;
        if (m_mode == 1 && (m_k % PL) == 0) exp_strb = 5'b10000 >> (m_k / PL);
        got_strb = {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk};
        chk_eq("strobes", 64'(got_strb), 64'(exp_strb));
        chk_eq("pc", 64'(pc), 64'(m_pc));
        chk_eq("running", 64'(running), 64'(m_mode == 1));
        chk_eq("halted", 64'(halted), 64'(m_mode == 2));
        chk_eq("instr_count", 64'(instr_count), 64'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    // Random values on every input that should be ignored this cycle.
    task automatic noise();
        start         = 1'($urandom);
        halt          = 1'($urandom);
        branch_opcode = 4'($urandom);
        alu_zero      = 1'($urandom);
        alu_lsb       = 1'($urandom);
        jmp_target    = 16'($urandom);
        jr_target     = 16'($urandom);
        br_offset     = 16'($urandom);
    endtask

    task automatic start_pulse();
        noise();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Run one full instruction from IF cycle 0, applying the given decision inputs.
    task automatic run_instr(input logic h, input logic [3:0] bo, input logic z, input logic l,
                             input logic [PC_W-1:0] jt, input logic [PC_W-1:0] jrt,
                             input logic [PC_W-1:0] off);
        for (int c = 0; c < ILEN; c++) begin
            noise();
            if (m_mode == 1 && m_k == ILEN - 1) begin
                halt = h; branch_opcode = bo; alu_zero = z; alu_lsb = l;
                jmp_target = jt; jr_target = jrt; br_offset = off;
            end
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        model_check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [PC_W-1:0] pc_before;
        start = 1'b0; halt = 1'b0; branch_opcode = 4'd0; alu_zero = 1'b0; alu_lsb = 1'b0;
        jmp_target = 16'd0; jr_target = 16'd0; br_offset = 16'd0;
        do_reset();
        // Idle without start: must stay put.
        for (int i = 0; i < 3; i++) step();

        // First instruction, fall-through.
        start_pulse();
        chk_eq("first_IF", 64'(IF_clk), 64'd1);
        run_instr(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        chk_eq("pc_after_first", 64'(pc), 64'h1);
        chk_eq("count_after_first", 64'(instr_count), 64'd1);

        run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0);
        chk_eq("jmp", 64'(pc), 64'h0040);
        run_instr(1'b0, 4'b0101, 1'b0, 1'b0, 16'h0, 16'h1234, 16'h0);
        chk_eq("jr", 64'(pc), 64'h1234);

        run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 16'd10, 16'h0, 16'h0);
        run_instr(1'b0, 4'b0110, 1'b1, 1'b0, 16'h0, 16'h0, 16'hFFFE);
        chk_eq("beq_taken", 64'(pc), 64'd8);
        run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 16'd10, 16'h0, 16'h0);
        run_instr(1'b0, 4'b0110, 1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFE);
        chk_eq("beq_not_taken", 64'(pc), 64'd11);
        run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 16'd10, 16'h0, 16'h0);
        run_instr(1'b0, 4'b0111, 1'b0, 1'b1, 16'h0, 16'h0, 16'd5);
        chk_eq("blt_taken", 64'(pc), 64'd15);
        run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0);
        run_instr(1'b0, 4'b1000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        chk_eq("pc_wrap", 64'(pc), 64'h0);

        // Random instructions, no halt.
        for (int i = 0; i < 30; i++)
            run_instr(1'b0, 4'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom));

        // Halt wins over a valid jump; HALTED is sticky against start.
        pc_before = pc;
        run_instr(1'b1, 4'b0100, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0);
        chk_eq("halt_pc", 64'(pc), 64'(pc_before));
        chk_eq("halt_flag", 64'(halted), 64'd1);
        for (int i = 0; i < 2 * ILEN; i++) begin
            noise();
            start = 1'b1;
            step();
        end

        // Reset during the ALU strobe cycle.
        do_reset();
        start_pulse();
        for (int i = 0; i < 2 * PL; i++) begin
            noise();
            step();
        end
        chk_eq("alu_strobe_before_reset", 64'(ALU_clk), 64'd1);
        #1;
        do_reset();
        chk_eq("pc_after_abort", 64'(pc), 64'h0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Random run including occasional halts.
        start_pulse();
        for (int i = 0; i < 25; i++)
            run_instr(1'($urandom_range(0, 7) == 0), 4'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
